// File: rtl/sdp_ram_8x1024_pkg.sv
// Shared sizing and types for the 1024 x 8 simple dual-port RAM.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package sdp_ram_pkg;

    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 8;
    localparam int BYTE_SIZE  = 8;
    localparam int BE_WIDTH   = DATA_WIDTH / BYTE_SIZE;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/sdp_ram_8x1024_if.sv
// Write/read port bundle for the simple dual-port RAM.
// Latency: none; this is wiring only.
// Backpressure: none; both ports accept one access every cycle.
interface sdp_ram_8x1024_if
    import sdp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = sdp_ram_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = sdp_ram_pkg::DATA_WIDTH,
    parameter int BE_WIDTH   = sdp_ram_pkg::BE_WIDTH
);

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BE_WIDTH-1:0]   wr_byte_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    // The client side drives both ports and receives read data.
    modport master (
        output wr_en, wr_addr, wr_data, wr_byte_en, rd_addr,
        input  rd_data
    );

    // The RAM side.
    modport slave (
        input  wr_en, wr_addr, wr_data, wr_byte_en, rd_addr,
        output rd_data
    );

endinterface

// File: rtl/sdp_ram_8x1024_lane.sv
// One byte lane of storage: depth x BYTE_SIZE array, one write and one read address.
// Latency: write lands on the clock edge; read path is combinational (the top registers it).
// Backpressure: none; one write per cycle, read address looked up continuously.
module sdp_ram_lane
    import sdp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = sdp_ram_pkg::ADDR_WIDTH,
    parameter int BYTE_SIZE  = sdp_ram_pkg::BYTE_SIZE
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [BYTE_SIZE-1:0]  wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [BYTE_SIZE-1:0]  rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Storage is never reset so that it maps onto block RAM.
    logic [BYTE_SIZE-1:0] mem [DEPTH];

    // Store the lane byte on the edge where the lane enable is high.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The top samples this on the same edge as the write, which gives read-first behaviour.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sdp_ram_8x1024.sv
// 1024 x 8 simple dual-port RAM with byte-lane write enables and a registered, read-first read.
// Latency: 1 cycle rd_addr -> rd_data; 2 cycles when SDP_RAM_OUTPUT_REG_EN is defined.
// Backpressure: none; one write and one independently addressed read accepted every cycle.
module sdp_ram_8x1024
    import sdp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = sdp_ram_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = sdp_ram_pkg::DATA_WIDTH,
    parameter int BYTE_SIZE  = sdp_ram_pkg::BYTE_SIZE,
    parameter int BE_WIDTH   = DATA_WIDTH / BYTE_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    sdp_ram_8x1024_if.slave  bus
);

    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_q;

    // One storage lane per byte; writes are held off while reset is asserted.
    for (genvar i = 0; i < BE_WIDTH; i++) begin : g_lane
        sdp_ram_lane #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .BYTE_SIZE  (BYTE_SIZE)
        ) u_lane (
            .clk     (clk),
            .we      (bus.wr_en & bus.wr_byte_en[i] & rst_n),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data[i*BYTE_SIZE +: BYTE_SIZE]),
            .rd_addr (bus.rd_addr),
            .rd_data (rd_word[i*BYTE_SIZE +: BYTE_SIZE])
        );
    end

    // Read stage: capture the addressed word every cycle, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_word;
        end
    end

`ifdef SDP_RAM_OUTPUT_REG_EN
    logic [DATA_WIDTH-1:0] out_q;

    // Extra output stage for timing closure; also cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= rd_q;
        end
    end

    assign bus.rd_data = out_q;
`else
    assign bus.rd_data = rd_q;
`endif

endmodule

// File: tb/tb_sdp_ram_8x1024.sv
// Self-checking bench for sdp_ram_8x1024: vector table plus hand-written sequences, scoreboard queue.
// Latency: follows SDP_RAM_OUTPUT_REG_EN (1 or 2 cycles).
// Backpressure: none; stimulus applied every cycle.
module tb_sdp_ram_8x1024;
    import sdp_ram_pkg::*;

`ifdef SDP_RAM_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst_n;

    sdp_ram_8x1024_if bus ();

    sdp_ram_8x1024 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic  chk;
        data_t exp;
        addr_t addr;
    } sb_t;

    typedef struct packed {
        logic  we;
        addr_t wa;
        data_t wd;
        logic  be;
        addr_t ra;
        logic  chk;
        data_t exp;
    } vec_t;

    sb_t   exp_q[$];
    vec_t  vecs[10];
    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    task automatic check(input string nm, input data_t act, input data_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: rd_data=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of traffic; pop the scoreboard entry whose read is now at the output.
    task automatic cycle(input logic we, input addr_t wa, input data_t wd, input logic be,
                         input addr_t ra, input logic chk, input data_t exp);
        sb_t e;
        @(negedge clk);
        bus.wr_en      = we;
        bus.wr_addr    = wa;
        bus.wr_data    = wd;
        bus.wr_byte_en = be;
        bus.rd_addr    = ra;
        exp_q.push_back('{chk: chk, exp: exp, addr: ra});
        @(posedge clk);
        #1;
        if (exp_q.size() >= LAT) begin
            e = exp_q.pop_front();
            if (e.chk) check($sformatf("%s addr=%0d", phase, e.addr), bus.rd_data, e.exp);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < LAT; i++) cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    function automatic data_t traffic_data(input int k);
        return data_t'(k) ^ 8'h96;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.wr_byte_en = '0;
        bus.rd_addr    = '0;

        // Vector table: byte enable, read-during-write, write strobe low.
        vecs[0] = '{we:1, wa:10'd7, wd:8'h5A, be:1, ra:10'd0, chk:0, exp:8'h00};
        vecs[1] = '{we:1, wa:10'd7, wd:8'hA5, be:0, ra:10'd0, chk:0, exp:8'h00};
        vecs[2] = '{we:0, wa:10'd0, wd:8'h00, be:0, ra:10'd7, chk:1, exp:8'h5A};
        vecs[3] = '{we:1, wa:10'd3, wd:8'h11, be:1, ra:10'd0, chk:0, exp:8'h00};
        vecs[4] = '{we:1, wa:10'd3, wd:8'h22, be:1, ra:10'd3, chk:1, exp:8'h11};
        vecs[5] = '{we:0, wa:10'd0, wd:8'h00, be:0, ra:10'd3, chk:1, exp:8'h22};
        vecs[6] = '{we:1, wa:10'd0, wd:8'h10, be:1, ra:10'd7, chk:1, exp:8'h5A};
        vecs[7] = '{we:0, wa:10'd0, wd:8'h99, be:1, ra:10'd0, chk:1, exp:8'h10};
        vecs[8] = '{we:0, wa:10'd0, wd:8'h00, be:0, ra:10'd0, chk:1, exp:8'h10};
        vecs[9] = '{we:1, wa:10'd7, wd:8'hC3, be:0, ra:10'd7, chk:1, exp:8'h5A};

        // 1a. Reset held with random read addresses: output stays zero.
        phase = "reset_hold";
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.rd_addr = addr_t'($urandom_range(0, 1023));
            @(posedge clk);
            #1;
            check(phase, bus.rd_data, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // 2. Fill every location, then read back sequentially.
        phase = "fill";
        for (int a = 0; a < 1024; a++)
            cycle(1'b1, addr_t'(a), 8'hFF - data_t'(a), 1'b1, '0, 1'b0, '0);
        phase = "readback";
        for (int a = 0; a < 1024; a++)
            cycle(1'b0, '0, '0, 1'b0, addr_t'(a), 1'b1, 8'hFF - data_t'(a));
        drain();

        // 1b. Reset pulse mid-read clears the output without a clock edge.
        phase = "pre_pulse";
        for (int i = 0; i <= LAT; i++) cycle(1'b0, '0, '0, 1'b0, 10'd10, 1'b1, 8'hF5);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", bus.rd_data, 8'h00);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // 3/4. Table-driven vectors.
        phase = "table";
        for (int i = 0; i < 10; i++)
            cycle(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].be,
                  vecs[i].ra, vecs[i].chk, vecs[i].exp);
        drain();

        // 5. Memory survives reset; a write attempted during reset is dropped.
        phase = "reset_keep";
        cycle(1'b1, 10'd1023, 8'h3C, 1'b1, '0, 1'b0, '0);
        @(negedge clk);
        rst_n          = 1'b0;
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 10'd1023;
        bus.wr_data    = 8'hEE;
        bus.wr_byte_en = 1'b1;
        @(posedge clk);
        #1;
        check("reset_keep_out", bus.rd_data, 8'h00);
        exp_q.delete();
        @(negedge clk);
        bus.wr_en = 1'b0;
        rst_n     = 1'b1;
        cycle(1'b0, '0, '0, 1'b0, 10'd1023, 1'b1, 8'h3C);
        cycle(1'b0, '0, '0, 1'b0, 10'd5, 1'b1, 8'hFA);
        drain();

        // 6. Full-rate traffic: write k while reading k-1.
        phase = "traffic";
        for (int k = 0; k < 1024; k++)
            cycle(1'b1, addr_t'(k), traffic_data(k), 1'b1, addr_t'(k - 1),
                  k > 0, traffic_data(k - 1));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
